systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 19 +
 rtl/skew_delay_line.sv | 31 +++
 rtl/systolic_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: FSM state encoding
// and the drain length used to flush the diagonal skew.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Zero rows needed after the last activation row so the deepest lane
   // has emptied and the array has seen the full wavefront (2N-1).
   function automatic int drain_len(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// One instance per array lane produces the diagonal skew.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one stage per clock; reset empties the whole line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage[s] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int s = 1; s < DEPTH; s++) begin
            stage[s] <= stage[s-1];
         end
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: loads N weight rows unskewed with a load strobe,
// then streams activation rows with a one-cycle-per-lane diagonal skew,
// drains 2N-1 zero rows and pulses done.
// Optional feature: define SYSTOLIC_FEEDER_BIAS_EN to add bias_valid /
// bias_data ports and a bias register that seeds sums_in_vector in the
// cycles where a lane carries activation data.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int N     = 2,
   parameter int WBITS = 8,
   parameter int ABITS = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_is_weight,
   input  logic               in_last,
   input  logic [WBITS*N-1:0] in_data,
`ifdef SYSTOLIC_FEEDER_BIAS_EN
   input  logic               bias_valid,
   input  logic [ABITS*N-1:0] bias_data,
`endif
   output logic               load,
   output logic [WBITS*N-1:0] weights_in_vector,
   output logic [ABITS*N-1:0] sums_in_vector,
   output logic               done
);

   localparam int DLEN = drain_len(N);
   localparam int WCW  = $clog2(N + 1);
   localparam int DCW  = $clog2(DLEN + 1);

`ifdef SYSTOLIC_FEEDER_BIAS_EN
   // Each lane carries a tag bit marking real activation data so the bias
   // can follow the data through the skew even when the data value is 0.
   localparam int LW = WBITS + 1;
`else
   localparam int LW = WBITS;
`endif

   state_t             state;
   logic               in_ready_reg;
   logic               done_reg;
   logic               load_reg;
   logic [WBITS*N-1:0] wt_reg;
   logic [WCW-1:0]     wcnt_reg;
   logic [DCW-1:0]     dcnt_reg;

   logic accept;
   logic wt_accept;
   logic act_accept;

   assign accept     = in_valid && in_ready_reg;
   assign wt_accept  = accept && ((state == IDLE && in_is_weight) || state == LOAD);
   assign act_accept = accept && ((state == IDLE && !in_is_weight) || state == STREAM);

   // Control FSM; in_ready and done are registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         in_ready_reg <= 1'b0;
         done_reg     <= 1'b0;
         wcnt_reg     <= '0;
         dcnt_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  if (in_is_weight) begin
                     if (N == 1) begin
                        state <= IDLE;
                     end else begin
                        state    <= LOAD;
                        wcnt_reg <= WCW'(1);
                     end
                  end else if (in_last) begin
                     state        <= DRAIN;
                     in_ready_reg <= 1'b0;
                     dcnt_reg     <= DCW'(DLEN - 1);
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            LOAD: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  if (wcnt_reg == WCW'(N - 1)) begin
                     state    <= IDLE;
                     wcnt_reg <= '0;
                  end else begin
                     wcnt_reg <= wcnt_reg + WCW'(1);
                  end
               end
            end
            STREAM: begin
               in_ready_reg <= 1'b1;
               if (accept && in_last) begin
                  state        <= DRAIN;
                  in_ready_reg <= 1'b0;
                  dcnt_reg     <= DCW'(DLEN - 1);
               end
            end
            DRAIN: begin
               in_ready_reg <= 1'b0;
               if (dcnt_reg == '0) begin
                  state    <= DONE;
                  done_reg <= 1'b1;
               end else begin
                  dcnt_reg <= dcnt_reg - DCW'(1);
               end
            end
            DONE: begin
               state        <= IDLE;
               in_ready_reg <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               in_ready_reg <= 1'b0;
            end
         endcase
      end
   end

   // Weight rows bypass the skew and are presented one cycle after acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_reg <= 1'b0;
         wt_reg   <= '0;
      end else begin
         load_reg <= wt_accept;
         wt_reg   <= wt_accept ? in_data : '0;
      end
   end

`ifdef SYSTOLIC_FEEDER_BIAS_EN
   logic [ABITS*N-1:0] bias_reg;

   // Bias is only updated while idle so it stays stable across a stream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bias_reg <= '0;
      end else if (state == IDLE && bias_valid) begin
         bias_reg <= bias_data;
      end
   end
`else
   assign sums_in_vector = '0;
`endif

   // Lane i is delayed by i+1 cycles; non-accepted cycles inject zero rows
   // so bubbles keep their spacing through the skew.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : lane_g
         logic [LW-1:0] lane_d;
         logic [LW-1:0] lane_q;

`ifdef SYSTOLIC_FEEDER_BIAS_EN
         assign lane_d = act_accept ? {1'b1, in_data[gi*WBITS +: WBITS]} : '0;
         assign sums_in_vector[gi*ABITS +: ABITS] =
            lane_q[WBITS] ? bias_reg[gi*ABITS +: ABITS] : '0;
`else
         assign lane_d = act_accept ? in_data[gi*WBITS +: WBITS] : '0;
`endif

         skew_delay_line #(
            .DEPTH (gi + 1),
            .WIDTH (LW)
         ) u_skew (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (lane_d),
            .q       (lane_q)
         );

         // The skew is always empty while weights load, so the mux never hides data.
         assign weights_in_vector[gi*WBITS +: WBITS] =
            load_reg ? wt_reg[gi*WBITS +: WBITS] : lane_q[WBITS-1:0];
      end
   endgenerate

   assign in_ready = in_ready_reg;
   assign load     = load_reg;
   assign done     = done_reg;

endmodule
